serial_paralelo_lanes: RTL

//  Multi-lane, parametrised serial-to-parallel converter for the PHY RX path.

---
 rtl/serial_paralelo_lanes_pkg.sv | 22 ++
 rtl/serial_paralelo_lanes_lane.sv | 124 ++++++++++++
 rtl/serial_paralelo_lanes.sv | 43 ++++
 3 files changed

// File: rtl/serial_paralelo_lanes_pkg.sv
// Shared definitions for the multi-lane serial-to-parallel converter.
//   sp_state_e      : per-lane alignment FSM state (2'd3 is illegal, recovers to search)
//   Default*        : default word width, comma/idle word and lock threshold
//   cnt_bits()      : counter width helper that never returns zero
package serial_paralelo_lanes_pkg;

    typedef enum logic [1:0] {
        StSearch = 2'd0,
        StCount  = 2'd1,
        StLocked = 2'd2
    } sp_state_e;

    localparam int unsigned DefaultWidth   = 8;
    localparam logic [7:0]  DefaultComma   = 8'hBC;
    localparam int unsigned DefaultLockCnt = 4;

    // Bits needed to hold values 0..n-1, at least 1.
    function automatic int unsigned cnt_bits(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_paralelo_lanes_lane.sv
// One deserialiser lane: MSB-first shift register, comma search, alignment
// counting and registered word output.
//   clk_i    : bit clock
//   rst_ni   : synchronous active-low reset
//   data_i   : serial input bit
//   word_o   : last aligned word captured while locked
//   valid_o  : word_o is data (not the comma word)
//   stb_o    : one-cycle pulse when word_o updates
//   locked_o : lane aligned and locked
module serial_paralelo_lanes_lane
    import serial_paralelo_lanes_pkg::*;
#(
    parameter int unsigned      WIDTH    = DefaultWidth,
    parameter logic [WIDTH-1:0] COMMA    = WIDTH'(DefaultComma),
    parameter int unsigned      LOCK_CNT = DefaultLockCnt
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             data_i,
    output logic [WIDTH-1:0] word_o,
    output logic             valid_o,
    output logic             stb_o,
    output logic             locked_o
);

    localparam int unsigned BitCntW   = cnt_bits(WIDTH);
    localparam int unsigned CommaCntW = cnt_bits(LOCK_CNT + 1);
    localparam logic [BitCntW-1:0]   LastBit    = BitCntW'(WIDTH - 1);
    localparam logic [CommaCntW-1:0] LockThresh = CommaCntW'(LOCK_CNT);
    localparam logic [CommaCntW-1:0] OneComma   = CommaCntW'(1);

    sp_state_e            state_q, state_d;
    logic [WIDTH-1:0]     sr_q, sr_d;
    logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CommaCntW-1:0] comma_cnt_q, comma_cnt_d;
    logic [WIDTH-1:0]     word_q, word_d;
    logic                 valid_q, valid_d;
    logic                 stb_q, stb_d;

    logic [WIDTH-1:0] sr_nxt;
    logic             is_comma;
    logic             boundary;

    always_comb begin
        sr_nxt   = {sr_q[WIDTH-2:0], data_i};
        is_comma = (sr_nxt == COMMA);
        boundary = (bit_cnt_q == LastBit);

        state_d     = state_q;
        sr_d        = sr_nxt;
        bit_cnt_d   = bit_cnt_q;
        comma_cnt_d = comma_cnt_q;
        word_d      = word_q;
        valid_d     = valid_q;
        stb_d       = 1'b0;

        // Word phase only runs once a comma has fixed the alignment.
        if (state_q != StSearch) begin
            bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;
        end

        case (state_q)
            StSearch: begin
                if (is_comma) begin
                    bit_cnt_d   = '0;
                    comma_cnt_d = OneComma;
                    state_d     = (LOCK_CNT <= 1) ? StLocked : StCount;
                end
            end
            StCount: begin
                if (boundary) begin
                    if (is_comma) begin
                        comma_cnt_d = comma_cnt_q + 1'b1;
                        if (comma_cnt_q + 1'b1 == LockThresh) begin
                            state_d = StLocked;
                        end
                    end else begin
                        // Search resumes on the next bit, not at this word's offset.
                        comma_cnt_d = '0;
                        state_d     = StSearch;
                    end
                end
            end
            StLocked: begin
                if (boundary) begin
                    word_d  = sr_nxt;
                    valid_d = !is_comma;
                    stb_d   = 1'b1;
                end
            end
            default: begin
                state_d     = StSearch;
                bit_cnt_d   = '0;
                comma_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StSearch;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            word_q      <= '0;
            valid_q     <= 1'b0;
            stb_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            word_q      <= word_d;
            valid_q     <= valid_d;
            stb_q       <= stb_d;
        end
    end

    assign word_o   = word_q;
    assign valid_o  = valid_q;
    assign stb_o    = stb_q;
    assign locked_o = (state_q == StLocked);

endmodule

// File: rtl/serial_paralelo_lanes.sv
// Multi-lane serial-to-parallel converter for the PHY RX path. Each lane
// aligns independently on a comma word and emits strobed parallel words.
//   clk_32f      : bit clock
//   reset_L      : synchronous active-low reset
//   data_in      : one serial bit per lane, MSB of each word first
//   sp_out       : parallel words, lane i at [i*WIDTH +: WIDTH]
//   valid_out_sp : lane word is data (not comma)
//   word_stb     : one-cycle pulse when the lane word updates
//   locked       : lane aligned and locked
module serial_paralelo_lanes
    import serial_paralelo_lanes_pkg::*;
#(
    parameter int unsigned      WIDTH    = DefaultWidth,
    parameter int unsigned      LANES    = 2,
    parameter logic [WIDTH-1:0] COMMA    = WIDTH'(DefaultComma),
    parameter int unsigned      LOCK_CNT = DefaultLockCnt
) (
    input  logic                   clk_32f,
    input  logic                   reset_L,
    input  logic [LANES-1:0]       data_in,
    output logic [LANES*WIDTH-1:0] sp_out,
    output logic [LANES-1:0]       valid_out_sp,
    output logic [LANES-1:0]       word_stb,
    output logic [LANES-1:0]       locked
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        serial_paralelo_lanes_lane #(
            .WIDTH   (WIDTH),
            .COMMA   (COMMA),
            .LOCK_CNT(LOCK_CNT)
        ) u_lane (
            .clk_i   (clk_32f),
            .rst_ni  (reset_L),
            .data_i  (data_in[i]),
            .word_o  (sp_out[i*WIDTH +: WIDTH]),
            .valid_o (valid_out_sp[i]),
            .stb_o   (word_stb[i]),
            .locked_o(locked[i])
        );
    end

endmodule
